filter_voice_sequencer: RTL and testbench

Time-multiplexes one shared sequential multiplier across `V` independent one-pole filter voices of the synthesizer. Each accepted sample strobe drives one frame. In a frame, every voice in turn computes `y = freq[v]*(x_prev[v] + y_prev[v]) + x[v]` and its delay-state registers are updated. The block sits between the DDS voice outputs and the mixer, and owns the only multiplier in the filter path.

---
 rtl/filter_voice_sequencer.sv | 162 ++++++++++++++++
 tb/tb_filter_voice_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_voice_sequencer.sv
// Shares one sequential multiplier across V one-pole filter voices.
// Each accepted sample strobe runs every voice once: y = f*(x_prev + y_prev) + x.
module filter_voice_sequencer #(
    parameter int n   = 12,
    parameter int V   = 4,
    parameter int TMO = 63
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           sample_stb,
    input  logic [V*n-1:0] in_flat,
    input  logic [V*n-1:0] freq_flat,
    output logic [n-1:0]   mult_a,
    output logic [n-1:0]   mult_b,
    output logic           mult_start,
    input  logic           mult_done,
    input  logic [n-1:0]   mult_p,
    output logic [V*n-1:0] out_flat,
    output logic           busy,
    output logic           frame_done,
    output logic           overrun,
    output logic           mult_err
);
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam int CW = $clog2(TMO + 1);
    localparam logic [VW-1:0] V_LAST = VW'(V - 1);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(TMO - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_r, state_s;
    logic [VW-1:0] v_r;
    logic [VW-1:0] v_next_s;
    logic [CW-1:0] cnt_r;
    logic [n-1:0]  x_prev_r [V];
    logic [n-1:0]  y_prev_r [V];
    logic [n-1:0]  x_cur_r  [V];
    logic [n-1:0]  f_r      [V];
    logic [n-1:0]  out_r    [V];
    logic [n-1:0]  mult_a_r, mult_b_r;
    logic          mult_start_r, busy_r, frame_done_r, overrun_r, mult_err_r;
    logic          accept_s, capture_s, timeout_s, drop_s, last_s;

    assign v_next_s = v_r + V_ONE;
    assign last_s   = (v_r == V_LAST);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and one-cycle event strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        timeout_s = 1'b0;
        drop_s    = sample_stb && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (sample_stb) begin
                    accept_s = 1'b1;
                    state_s  = REQ;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: state_s = WAIT;
            WAIT: begin
                if (mult_done) begin
                    capture_s = 1'b1;
                    state_s   = last_s ? DONE : REQ;
                end else if (cnt_r == C_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: voice state, operand registers, counters and status flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            v_r          <= '0;
            cnt_r        <= '0;
            mult_a_r     <= '0;
            mult_b_r     <= '0;
            mult_start_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            mult_err_r   <= 1'b0;
            for (int i = 0; i < V; i++) begin
                x_prev_r[i] <= '0;
                y_prev_r[i] <= '0;
                x_cur_r[i]  <= '0;
                f_r[i]      <= '0;
                out_r[i]    <= '0;
            end
        end else begin
            mult_start_r <= (state_s == REQ);
            busy_r       <= (state_s != IDLE);
            frame_done_r <= (state_s == DONE);
            overrun_r    <= overrun_r | drop_s;
            mult_err_r   <= mult_err_r | timeout_s;

            if (state_r == REQ) begin
                cnt_r <= '0;
            end else if ((state_r == WAIT) && !mult_done) begin
                cnt_r <= cnt_r + C_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            // Operands for the next REQ are formed on the edge that enters it.
            if (accept_s) begin
                v_r      <= '0;
                mult_a_r <= x_prev_r[0] + y_prev_r[0];
                mult_b_r <= freq_flat[0 +: n];
                for (int i = 0; i < V; i++) begin
                    x_cur_r[i] <= in_flat[i*n +: n];
                    f_r[i]     <= freq_flat[i*n +: n];
                end
            end else if (capture_s) begin
                out_r[v_r]    <= mult_p + x_cur_r[v_r];
                y_prev_r[v_r] <= mult_p + x_cur_r[v_r];
                x_prev_r[v_r] <= x_cur_r[v_r];
                if (!last_s) begin
                    v_r      <= v_next_s;
                    mult_a_r <= x_prev_r[v_next_s] + y_prev_r[v_next_s];
                    mult_b_r <= f_r[v_next_s];
                end else begin
                    v_r <= v_r;
                end
            end else begin
                v_r <= v_r;
            end
        end
    end

    for (genvar g = 0; g < V; g++) begin : g_out
        assign out_flat[g*n +: n] = out_r[g];
    end

    assign mult_a     = mult_a_r;
    assign mult_b     = mult_b_r;
    assign mult_start = mult_start_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;
    assign mult_err   = mult_err_r;
endmodule

// File: tb/tb_filter_voice_sequencer.sv
// Directed bench for filter_voice_sequencer with a fixed-latency multiplier model.
module tb_filter_voice_sequencer;
    localparam int N   = 12;
    localparam int V   = 4;
    localparam int TMO = 63;
    localparam int L   = 3;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic           sample_stb;
    logic [V*N-1:0] in_flat, freq_flat;
    logic [N-1:0]   mult_a, mult_b, mult_p;
    logic           mult_start, mult_done;
    logic [V*N-1:0] out_flat;
    logic           busy, frame_done, overrun, mult_err;

    logic           model_done, spur_done;
    logic [N-1:0]   model_p, spur_p;
    int             block_voice;
    int             done_count = 0;
    int             start_count = 0;
    int             n_cmp = 0;
    int             n_bad = 0;

    assign mult_done = model_done | spur_done;
    assign mult_p    = spur_done ? spur_p : model_p;

    always #5 Clk = ~Clk;

    filter_voice_sequencer #(.n(N), .V(V), .TMO(TMO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .sample_stb(sample_stb),
        .in_flat(in_flat), .freq_flat(freq_flat),
        .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
        .mult_done(mult_done), .mult_p(mult_p), .out_flat(out_flat),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .mult_err(mult_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [V*N-1:0] pk(input int a, input int b, input int c, input int d);
        pk = {N'(d), N'(c), N'(b), N'(a)};
    endfunction

    // Multiplier model: done exactly L cycles after the start cycle; voice block_voice never answers.
    initial begin
        logic [N-1:0]   a, b;
        logic [2*N-1:0] prod;
        int             k;
        model_done = 1'b0;
        model_p    = '0;
        k          = 0;
        forever begin
            @(negedge Clk);
            model_done = 1'b0;
            if (!busy) k = 0;
            if (mult_start && Rst_n) begin
                if (k != block_voice) begin
                    a = mult_a;
                    b = mult_b;
                    k++;
                    repeat (L) @(negedge Clk);
                    prod       = a * b;
                    model_p    = prod[N-1:0];
                    model_done = 1'b1;
                end else begin
                    k++;
                end
            end
        end
    end

    // Event counters for pulse-count checks.
    initial begin
        forever begin
            @(negedge Clk);
            if (frame_done) done_count++;
            if (mult_start) start_count++;
        end
    end

    // One frame: strobe, optional duplicate strobe / spurious done, wait for frame_done.
    task automatic run_frame(input int dup_at, input int spur_at, output int cyc,
                             output logic [N-1:0] a1, output logic [N-1:0] b1,
                             output logic st1, output logic bsy_done, output logic bsy_idle);
        @(negedge Clk);
        sample_stb = 1'b1;
        @(negedge Clk);
        cyc        = 1;
        sample_stb = (dup_at == 1);
        a1         = mult_a;
        b1         = mult_b;
        st1        = mult_start;
        spur_done  = (spur_at == 1);
        spur_p     = 12'd999;
        while (!frame_done && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            sample_stb = (cyc == dup_at);
            spur_done  = (cyc == spur_at);
        end
        sample_stb = 1'b0;
        spur_done  = 1'b0;
        bsy_done   = busy;
        @(negedge Clk);
        bsy_idle   = busy;
    endtask

    initial begin
        int           cyc, d0, s0;
        logic [N-1:0] a1, b1;
        logic         st1, bd, bi;

        Rst_n       = 1'b0;
        sample_stb  = 1'b0;
        in_flat     = '0;
        freq_flat   = '0;
        spur_done   = 1'b0;
        spur_p      = '0;
        block_voice = -1;
        repeat (3) @(negedge Clk);
        check_val("rst_out", out_flat, 64'd0);
        check_val("rst_flags", {busy, frame_done, overrun, mult_err, mult_start}, 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_val("rst_rel_busy", busy, 64'd0);

        // Frame 1 and 2 from fresh state.
        in_flat   = pk(10, 20, 30, 40);
        freq_flat = pk(1, 2, 3, 4);
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("f1_latency", cyc, 64'd17);
        check_val("f1_req_start", st1, 64'd1);
        check_val("f1_out", out_flat, pk(10, 20, 30, 40));
        check_val("f1_busy_done", bd, 64'd1);
        check_val("f1_busy_idle", bi, 64'd0);
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("f2_latency", cyc, 64'd17);
        check_val("f2_req_a", a1, 64'd20);
        check_val("f2_out", out_flat, pk(30, 100, 210, 360));

        // Spurious done in IDLE, then in REQ.
        @(negedge Clk);
        spur_done = 1'b1;
        spur_p    = 12'd999;
        @(negedge Clk);
        spur_done = 1'b0;
        @(negedge Clk);
        check_val("spur_idle_out", out_flat, pk(30, 100, 210, 360));
        check_val("spur_idle_busy", busy, 64'd0);
        run_frame(0, 1, cyc, a1, b1, st1, bd, bi);
        check_val("spur_req_start", st1, 64'd1);
        check_val("spur_req_latency", cyc, 64'd17);
        check_val("spur_req_out", out_flat, pk(50, 260, 750, 1640));

        // Reset in the middle of voice 0 WAIT.
        @(negedge Clk);
        sample_stb = 1'b1;
        @(negedge Clk);
        sample_stb = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check_val("midrst_out", out_flat, 64'd0);
        check_val("midrst_ops", {mult_a, mult_b}, 64'd0);
        check_val("midrst_flags", {busy, frame_done, overrun, mult_err, mult_start}, 64'd0);
        s0 = start_count;
        d0 = done_count;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (25) @(negedge Clk);
        #1;
        check_val("midrst_no_start", start_count, s0);
        check_val("midrst_no_done", done_count, d0);
        check_val("midrst_out_after", out_flat, 64'd0);

        // Overrun: duplicate strobe three cycles after accept.
        in_flat   = pk(10, 20, 30, 40);
        freq_flat = pk(1, 2, 3, 4);
        d0 = done_count;
        run_frame(3, 0, cyc, a1, b1, st1, bd, bi);
        check_val("ovr_latency", cyc, 64'd17);
        check_val("ovr_flag", overrun, 64'd1);
        check_val("ovr_out", out_flat, pk(10, 20, 30, 40));
        repeat (5) @(negedge Clk);
        #1;
        check_val("ovr_one_done", done_count, d0 + 1);

        // Timeout on voice 2.
        block_voice = 2;
        in_flat     = pk(1, 2, 3, 4);
        freq_flat   = pk(1, 1, 1, 1);
        @(negedge Clk);
        sample_stb = 1'b1;
        @(negedge Clk);
        sample_stb = 1'b0;
        #1;
        d0  = done_count;
        cyc = 1;
        while (cyc < 72) begin
            @(negedge Clk);
            cyc++;
        end
        check_val("tmo_err_before", mult_err, 64'd0);
        check_val("tmo_busy_before", busy, 64'd1);
        @(negedge Clk);
        check_val("tmo_err_at", mult_err, 64'd1);
        check_val("tmo_busy_at", busy, 64'd0);
        check_val("tmo_out", out_flat, pk(21, 42, 30, 40));
        repeat (3) @(negedge Clk);
        #1;
        check_val("tmo_no_done", done_count, d0);
        block_voice = -1;
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("tmo_next_latency", cyc, 64'd17);
        check_val("tmo_next_out", out_flat, pk(23, 46, 63, 84));
        check_val("tmo_err_sticky", mult_err, 64'd1);

        // Wrap-around: build x_prev=4000, y_prev=200, then feed x=100, freq=1.
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        check_val("wrap_rst_flags", {overrun, mult_err}, 64'd0);
        in_flat   = pk(148, 148, 148, 148);
        freq_flat = pk(1, 1, 1, 1);
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("wrap_a_out", out_flat, pk(148, 148, 148, 148));
        in_flat = pk(4000, 4000, 4000, 4000);
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("wrap_b_out", out_flat, pk(200, 200, 200, 200));
        in_flat = pk(100, 100, 100, 100);
        run_frame(0, 0, cyc, a1, b1, st1, bd, bi);
        check_val("wrap_mult_a", a1, 64'd104);
        check_val("wrap_mult_b", b1, 64'd1);
        check_val("wrap_out", out_flat, pk(204, 204, 204, 204));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
